// File: rtl/conv_pkg.sv
// Shared types and constants for the conv window sequencer slice.
package conv_pkg;

    localparam int unsigned VEC_W      = 64;
    localparam int unsigned CH_PER_VEC = 8;
    localparam int unsigned CH_SHIFT   = $clog2(CH_PER_VEC);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream,
        StDone
    } seq_state_t;

    typedef struct packed {
        logic [15:0] channels;
        logic [15:0] width;
        logic [15:0] height;
        logic        stride2;
    } cfg_t;

    // A frame needs at least one full 3x3 window and must fit the counters.
    function automatic logic cfg_bad(cfg_t c, int unsigned max_groups, int unsigned max_dim);
        logic [31:0] groups;
        logic [31:0] w;
        logic [31:0] h;
        groups = 32'(c.channels >> CH_SHIFT);
        w      = 32'(c.width);
        h      = 32'(c.height);
        return (c.channels == 16'd0) ||
               (c.channels[CH_SHIFT-1:0] != '0) ||
               (groups > max_groups) ||
               (w < 32'd3) || (h < 32'd3) ||
               (w > max_dim) || (h > max_dim);
    endfunction

endpackage

// File: rtl/pos_counter.sv
// Nested channel-group / column / row position counter with wrap flags.
module pos_counter #(
    parameter int unsigned GW = 7,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [GW-1:0] g_max_i,
    input  logic [DW-1:0] col_max_i,
    input  logic [DW-1:0] row_max_i,
    output logic [GW-1:0] g_o,
    output logic [DW-1:0] col_o,
    output logic [DW-1:0] row_o,
    output logic          g_wrap_o,
    output logic          col_wrap_o,
    output logic          row_wrap_o
);

    logic [GW-1:0] g_q, g_d;
    logic [DW-1:0] col_q, col_d;
    logic [DW-1:0] row_q, row_d;

    assign g_wrap_o   = (g_q == g_max_i);
    assign col_wrap_o = (col_q == col_max_i);
    assign row_wrap_o = (row_q == row_max_i);

    always_comb begin
        g_d   = g_q;
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            g_d   = '0;
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (!g_wrap_o) begin
                g_d = g_q + 1'b1;
            end else begin
                g_d = '0;
                if (!col_wrap_o) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = '0;
                    row_d = row_wrap_o ? '0 : row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            g_q   <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            g_q   <= g_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign g_o   = g_q;
    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/conv_window_sequencer.sv
// Frame controller: latches the layer config, gates the pixel-vector stream into the
// 3x3 window generator and tags each window with its post-stride output position.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned MAX_GROUPS = 128,
    parameter int unsigned MAX_DIM    = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      cfg_in_channels,
    input  logic [15:0]      cfg_img_width,
    input  logic [15:0]      cfg_img_height,
    input  logic             cfg_stride2,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    input  logic             s_valid,
    input  logic [VEC_W-1:0] s_data,
    output logic             s_ready,
    output logic             win_rst,
    output logic             win_data_valid,
    output logic [VEC_W-1:0] win_pixel,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last_group,
    output logic             m_last,
    output logic [15:0]      m_row,
    output logic [15:0]      m_col
);

    localparam int unsigned GW = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;

    seq_state_t state_q, state_d;
    cfg_t       cfg_q, cfg_d, cfg_in;
    logic       cfg_err_q, cfg_err_d;

    logic [GW-1:0] g, g_max;
    logic [15:0]   row, col;
    logic [15:0]   row_max, col_max;
    logic [15:0]   last_row, last_col;
    logic          g_wrap, col_wrap, row_wrap;
    logic          pos_ok, accept, frame_end;

    assign cfg_in = '{
        channels: cfg_in_channels,
        width:    cfg_img_width,
        height:   cfg_img_height,
        stride2:  cfg_stride2
    };

    assign g_max   = GW'((cfg_q.channels >> CH_SHIFT) - 16'd1);
    assign col_max = cfg_q.width - 16'd1;
    assign row_max = cfg_q.height - 16'd1;

    // With stride 2 the final output sits on the largest even index, not the edge.
    assign last_col = cfg_q.stride2 ? {col_max[15:1], 1'b0} : col_max;
    assign last_row = cfg_q.stride2 ? {row_max[15:1], 1'b0} : row_max;

    pos_counter #(
        .GW (GW),
        .DW (16)
    ) u_pos_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (state_q == StLoad),
        .en_i       (accept),
        .g_max_i    (g_max),
        .col_max_i  (col_max),
        .row_max_i  (row_max),
        .g_o        (g),
        .col_o      (col),
        .row_o      (row),
        .g_wrap_o   (g_wrap),
        .col_wrap_o (col_wrap),
        .row_wrap_o (row_wrap)
    );

    assign pos_ok = (row >= 16'd2) && (col >= 16'd2) &&
                    (!cfg_q.stride2 || (!row[0] && !col[0]));

    assign accept    = (state_q == StStream) && s_valid && s_ready;
    assign frame_end = accept && g_wrap && col_wrap && row_wrap;

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    cfg_d     = cfg_in;
                    cfg_err_d = cfg_bad(cfg_in, MAX_GROUPS, MAX_DIM);
                    state_d   = cfg_err_d ? StDone : StLoad;
                end
            end
            StLoad:   state_d = StStream;
            StStream: if (frame_end) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cfg_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        s_ready        = 1'b0;
        win_data_valid = 1'b0;
        m_valid        = 1'b0;
        m_last_group   = 1'b0;
        m_last         = 1'b0;
        m_row          = 16'd0;
        m_col          = 16'd0;
        if (state_q == StStream) begin
            // Only windows that produce an output wait on the consumer.
            s_ready        = !pos_ok || m_ready;
            win_data_valid = s_valid && s_ready;
            m_valid        = s_valid && pos_ok;
            m_last_group   = g_wrap;
            m_last         = m_valid && g_wrap && (row == last_row) && (col == last_col);
            if (m_valid) begin
                m_row = (row - 16'd2) >> cfg_q.stride2;
                m_col = (col - 16'd2) >> cfg_q.stride2;
            end
        end
    end

    assign busy      = (state_q == StLoad) || (state_q == StStream);
    assign done      = (state_q == StDone);
    assign cfg_err   = cfg_err_q;
    assign win_rst   = rst || (state_q != StStream);
    assign win_pixel = s_data;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed table-driven bench for conv_window_sequencer with a per-cycle position model.
module tb_conv_window_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_in_channels = 16'd0;
    logic [15:0] cfg_img_width = 16'd0;
    logic [15:0] cfg_img_height = 16'd0;
    logic        cfg_stride2 = 1'b0;
    logic        busy, done, cfg_err;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = 64'd0;
    logic        s_ready;
    logic        win_rst, win_data_valid;
    logic [63:0] win_pixel;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last_group, m_last;
    logic [15:0] m_row, m_col;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    conv_window_sequencer #(
        .MAX_GROUPS (128),
        .MAX_DIM    (1024)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_in_channels (cfg_in_channels),
        .cfg_img_width   (cfg_img_width),
        .cfg_img_height  (cfg_img_height),
        .cfg_stride2     (cfg_stride2),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .win_rst         (win_rst),
        .win_data_valid  (win_data_valid),
        .win_pixel       (win_pixel),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last_group    (m_last_group),
        .m_last          (m_last),
        .m_row           (m_row),
        .m_col           (m_col)
    );

    typedef struct {
        int ch;
        int w;
        int h;
        bit s2;
        bit err;
        int acc;
        int beats;
        int first;
        int lr;
        int lc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain; 1: consumer stall at first output; 2: valid gaps plus a stray start.
    task automatic run_frame(input vec_t v, input int mode);
        int  mr = 0, mc = 0, mg = 0;
        int  acc = 0, beats = 0, first = -1, lastr = -1, lastc = -1, nlast = 0;
        int  stalls = 0, cyc = 0, hold = 0;
        int  g_cnt, last_r, last_c;
        bit  fin = 0, pulsed = 0;
        bit  pos_ok, exp_ready, exp_acc, exp_mv, exp_last;
        g_cnt  = v.ch / 8;
        last_r = v.s2 ? ((v.h - 1) & ~1) : v.h - 1;
        last_c = v.s2 ? ((v.w - 1) & ~1) : v.w - 1;

        cfg_in_channels = 16'(v.ch);
        cfg_img_width   = 16'(v.w);
        cfg_img_height  = 16'(v.h);
        cfg_stride2     = v.s2;
        start   = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", s_ready, 0);
        chk("idle_busy", busy, 0);
        tick();
        start = 1'b0;
        // Scramble the config inputs: the frame must run from the latched copy.
        cfg_in_channels = 16'd64;
        cfg_img_width   = 16'd9;
        cfg_img_height  = 16'd9;
        cfg_stride2     = ~v.s2;
        @(negedge clk);
        if (v.err) begin
            chk("err_cfg_err", cfg_err, 1);
            chk("err_done", done, 1);
            chk("err_s_ready", s_ready, 0);
            chk("err_busy", busy, 0);
            tick();
            @(negedge clk);
            chk("err_done_clr", done, 0);
            chk("err_sticky", cfg_err, 1);
            chk("err_idle_s_ready", s_ready, 0);
            tick();
            return;
        end
        chk("load_cfg_err", cfg_err, 0);
        chk("load_busy", busy, 1);
        chk("load_win_rst", win_rst, 1);
        chk("load_s_ready", s_ready, 0);
        chk("load_done", done, 0);
        tick();

        while (!fin && cyc < 5000) begin
            pos_ok = (mr >= 2) && (mc >= 2) && (!v.s2 || ((mr % 2 == 0) && (mc % 2 == 0)));
            s_valid = (mode == 2) ? (cyc % 4 != 3) : 1'b1;
            s_data  = {$urandom, $urandom};
            if (mode == 1 && hold < 3) begin
                m_ready = 1'b0;
                if (pos_ok) hold++;
            end else begin
                m_ready = 1'b1;
            end
            if (mode == 2 && acc == 5 && !pulsed) begin
                start = 1'b1;
                cfg_in_channels = 16'd16;
                cfg_img_width   = 16'd8;
                cfg_img_height  = 16'd8;
                pulsed = 1;
            end
            exp_ready = !pos_ok || m_ready;
            exp_acc   = s_valid && exp_ready;
            exp_mv    = s_valid && pos_ok;
            exp_last  = exp_mv && (mg == g_cnt - 1) && (mr == last_r) && (mc == last_c);
            @(negedge clk);
            chk("s_ready", s_ready, exp_ready);
            chk("win_data_valid", win_data_valid, exp_acc);
            chk("m_valid", m_valid, exp_mv);
            chk("m_last_group", m_last_group, mg == g_cnt - 1);
            chk("m_last", m_last, exp_last);
            chk("stream_busy", busy, 1);
            chk("stream_done", done, 0);
            chk("stream_win_rst", win_rst, 0);
            if (exp_acc) chk("win_pixel", win_pixel, s_data);
            if (exp_mv) begin
                chk("m_row", m_row, 64'((mr - 2) >> v.s2));
                chk("m_col", m_col, 64'((mc - 2) >> v.s2));
            end
            if (!exp_ready) stalls++;
            if (m_valid && first < 0) first = acc;
            if (m_valid && win_data_valid) beats++;
            if (m_last && win_data_valid) begin
                nlast++;
                lastr = int'(m_row);
                lastc = int'(m_col);
            end
            if (exp_acc) begin
                acc++;
                if (mg == g_cnt - 1) begin
                    mg = 0;
                    if (mc == v.w - 1) begin
                        mc = 0;
                        if (mr == v.h - 1) fin = 1;
                        else mr++;
                    end else begin
                        mc++;
                    end
                end else begin
                    mg++;
                end
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        chk("frame_completed", fin, 1);
        s_valid = 1'b1;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_s_ready", s_ready, 0);
        chk("done_m_valid", m_valid, 0);
        tick();
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("idle_after_s_ready", s_ready, 0);
        chk("accepts", acc, v.acc);
        chk("beats", beats, v.beats);
        chk("first_beat_idx", first, v.first);
        chk("last_m_row", lastr, v.lr);
        chk("last_m_col", lastc, v.lc);
        chk("m_last_count", nlast, 1);
        chk("stall_cycles", stalls, (mode == 1) ? 3 : 0);
        s_valid = 1'b0;
        tick();
    endtask

    initial begin
        //         ch    w     h   s2 err  acc  beats first lr lc
        tbl[0]  = '{8,    4,    4,  0, 0,  16,    4,   10, 1, 1};
        tbl[1]  = '{16,   5,    5,  1, 0,  50,    8,   24, 1, 1};
        tbl[2]  = '{12,   4,    4,  0, 1,   0,    0,    0, 0, 0};
        tbl[3]  = '{8,    3,    3,  0, 0,   9,    1,    8, 0, 0};
        tbl[4]  = '{0,    4,    4,  0, 1,   0,    0,    0, 0, 0};
        tbl[5]  = '{8,    6,    4,  1, 0,  24,    2,   14, 0, 1};
        tbl[6]  = '{8,    2,    4,  0, 1,   0,    0,    0, 0, 0};
        tbl[7]  = '{24,   3,    4,  0, 0,  36,    6,   24, 1, 0};
        tbl[8]  = '{1032, 4,    4,  0, 1,   0,    0,    0, 0, 0};
        tbl[9]  = '{1024, 3,    3,  0, 0, 1152, 128, 1024, 0, 0};
        tbl[10] = '{8,    1025, 4,  0, 1,   0,    0,    0, 0, 0};
        tbl[11] = '{8,    4,    2,  0, 1,   0,    0,    0, 0, 0};

        s_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_win_data_valid", win_data_valid, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_last_group", m_last_group, 0);
        chk("rst_m_row", m_row, 0);
        chk("rst_m_col", m_col, 0);
        chk("rst_win_rst", win_rst, 1);
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_frame(tbl[i], 0);

        run_frame(tbl[0], 1);
        run_frame(tbl[0], 2);

        // Abort after 7 accepts (all before the first output position).
        cfg_in_channels = 16'd8;
        cfg_img_width   = 16'd4;
        cfg_img_height  = 16'd4;
        cfg_stride2     = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("abort_pre_accept", win_data_valid, 1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_win_rst", win_rst, 1);
        chk("abort_s_ready", s_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        s_valid = 1'b0;
        tick();
        run_frame(tbl[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
